// File: rtl/hicore_mem_queue_arb.sv
// rtl/hicore_mem_queue_arb.sv - two-requester arbiter feeding the memory-issue queue, with a lockstep source-tag FIFO
// Optional: HICORE_MQARB_FIXED_PRIO_EN selects fixed priority (requester 0 wins ties) instead of round-robin.
module hicore_mem_queue_arb #(
    parameter int DW      = 64,
    parameter int DP      = 4,
    parameter int LOGDP   = 2,
    parameter int MAX_OUT = 3,
    parameter int CW      = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          r0_valid,
    output logic          r0_ready,
    input  logic          r0_cancel,
    input  logic [DW-1:0] r0_info,
    input  logic          r1_valid,
    output logic          r1_ready,
    input  logic          r1_cancel,
    input  logic [DW-1:0] r1_info,
    output logic          q_i_valid,
    input  logic          q_i_ready,
    output logic          q_i_cancel,
    output logic [DW-1:0] q_i_info,
    input  logic          q_o_valid,
    input  logic          q_o_ready,
    output logic          o_src,
    input  logic          flush,
    output logic [CW-1:0] cnt0,
    output logic [CW-1:0] cnt1
);

    logic [LOGDP:0] wr_ptr_q, wr_ptr_d;
    logic [LOGDP:0] rd_ptr_q, rd_ptr_d;
    logic           tag_q [DP];
    logic [CW-1:0]  cnt0_q, cnt0_d;
    logic [CW-1:0]  cnt1_q, cnt1_d;
    logic           tag_full, tag_empty;
    logic           elig0, elig1, grant0, grant1;
    logic           accept, pop, head_src, dec0, dec1;

    assign tag_full  = (wr_ptr_q[LOGDP] != rd_ptr_q[LOGDP]) &&
                       (wr_ptr_q[LOGDP-1:0] == rd_ptr_q[LOGDP-1:0]);
    assign tag_empty = (wr_ptr_q == rd_ptr_q);

    assign elig0 = r0_valid & (cnt0_q < CW'(MAX_OUT)) & q_i_ready & ~flush & ~tag_full;
    assign elig1 = r1_valid & (cnt1_q < CW'(MAX_OUT)) & q_i_ready & ~flush & ~tag_full;

`ifdef HICORE_MQARB_FIXED_PRIO_EN
    assign grant0 = elig0;
    assign grant1 = elig1 & ~elig0;
`else
    // last_grant_q = 1 means requester 1 was served last, so requester 0 wins the next tie.
    logic last_grant_q, last_grant_d;

    assign grant0 = elig0 & (~elig1 | last_grant_q);
    assign grant1 = elig1 & (~elig0 | ~last_grant_q);
    assign last_grant_d = accept ? grant1 : last_grant_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    assign r0_ready   = grant0;
    assign r1_ready   = grant1;
    assign q_i_valid  = grant0 | grant1;
    assign q_i_info   = grant0 ? r0_info   : (grant1 ? r1_info   : '0);
    assign q_i_cancel = grant0 ? r0_cancel : (grant1 ? r1_cancel : 1'b0);

    assign accept   = q_i_valid & q_i_ready;
    // A pop against an empty tag FIFO is a protocol error; it is flagged below and ignored here.
    assign pop      = q_o_valid & q_o_ready & ~tag_empty;
    assign head_src = tag_q[rd_ptr_q[LOGDP-1:0]];
    assign dec0     = pop & ~head_src;
    assign dec1     = pop & head_src;

    assign wr_ptr_d = accept ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = pop    ? rd_ptr_q + 1'b1 : rd_ptr_q;
    assign cnt0_d   = cnt0_q + CW'(grant0) - CW'(dec0);
    assign cnt1_d   = cnt1_q + CW'(grant1) - CW'(dec1);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt0_q   <= '0;
            cnt1_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt0_q   <= cnt0_d;
            cnt1_q   <= cnt1_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_q[wr_ptr_q[LOGDP-1:0]] <= grant1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(q_o_valid && q_o_ready && tag_empty));
            assert (!(cnt0_q == CW'(DP) && grant0 && !dec0));
            assert (!(cnt1_q == CW'(DP) && grant1 && !dec1));
            assert (!(cnt0_q == '0 && dec0 && !grant0));
            assert (!(cnt1_q == '0 && dec1 && !grant1));
        end
    end

    assign o_src = head_src;
    assign cnt0  = cnt0_q;
    assign cnt1  = cnt1_q;

endmodule

// File: tb/tb_hicore_mem_queue_arb.sv
// tb/tb_hicore_mem_queue_arb.sv - directed scoreboard bench for hicore_mem_queue_arb
module tb_hicore_mem_queue_arb;
    localparam int DW = 64;
    localparam int DP = 4;
    localparam int MAX_OUT = 3;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          r0_valid, r0_ready, r0_cancel;
    logic [DW-1:0] r0_info;
    logic          r1_valid, r1_ready, r1_cancel;
    logic [DW-1:0] r1_info;
    logic          q_i_valid, q_i_ready, q_i_cancel;
    logic [DW-1:0] q_i_info;
    logic          q_o_valid, q_o_ready, o_src, flush;
    logic [CW-1:0] cnt0, cnt1;

    int checks = 0;
    int errors = 0;

    // Reference state: scoreboard of owner ids, per-requester occupancy, round-robin pointer, queue fill.
    int sb[$];
    int mcnt[2];
    int mlast;
    int qcnt;
    int gseq[$];

    always #5 clk = ~clk;

    hicore_mem_queue_arb dut (
        .clk(clk), .rst(rst),
        .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_cancel(r0_cancel), .r0_info(r0_info),
        .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_cancel(r1_cancel), .r1_info(r1_info),
        .q_i_valid(q_i_valid), .q_i_ready(q_i_ready), .q_i_cancel(q_i_cancel), .q_i_info(q_i_info),
        .q_o_valid(q_o_valid), .q_o_ready(q_o_ready), .o_src(o_src), .flush(flush),
        .cnt0(cnt0), .cnt1(cnt1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        mcnt[0] = 0;
        mcnt[1] = 0;
        mlast = 1;
        qcnt = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        r0_valid = 1'b0; r1_valid = 1'b0; q_o_ready = 1'b0; flush = 1'b0;
        q_i_ready = 1'b1; q_o_valid = 1'b0;
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_cnt0", 64'(cnt0), 64'd0);
        chk("rst_cnt1", 64'(cnt1), 64'd0);
    endtask

    task automatic step(input logic v0, input logic v1, input logic ordy, input logic fl, output int w);
        logic          e0, e1, c0, c1;
        logic [DW-1:0] i0, i1, exp_info;
        logic          exp_cancel;
        int            head;
        i0 = {$urandom, $urandom};
        i1 = {$urandom, $urandom};
        c0 = 1'($urandom_range(0, 1));
        c1 = 1'($urandom_range(0, 1));
        r0_valid = v0; r0_info = i0; r0_cancel = c0;
        r1_valid = v1; r1_info = i1; r1_cancel = c1;
        q_i_ready = (qcnt < DP);
        q_o_valid = (qcnt > 0);
        q_o_ready = ordy;
        flush = fl;
        @(negedge clk);
        e0 = v0 && (mcnt[0] < MAX_OUT) && q_i_ready && !fl && (sb.size() < DP);
        e1 = v1 && (mcnt[1] < MAX_OUT) && q_i_ready && !fl && (sb.size() < DP);
        w = -1;
        if (e0 && e1) w = (mlast == 0) ? 1 : 0;
        else if (e0) w = 0;
        else if (e1) w = 1;
        exp_info   = (w == 0) ? i0 : ((w == 1) ? i1 : '0);
        exp_cancel = (w == 0) ? c0 : ((w == 1) ? c1 : 1'b0);
        chk("r0_ready", 64'(r0_ready), 64'(w == 0));
        chk("r1_ready", 64'(r1_ready), 64'(w == 1));
        chk("q_i_valid", 64'(q_i_valid), 64'(w >= 0));
        chk("q_i_info", q_i_info, exp_info);
        chk("q_i_cancel", 64'(q_i_cancel), 64'(exp_cancel));
        if (q_o_valid && ordy) begin
            head = sb.pop_front();
            chk("o_src", 64'(o_src), 64'(head));
            mcnt[head]--;
            qcnt--;
        end
        if (w >= 0) begin
            sb.push_back(w);
            mcnt[w]++;
            mlast = w;
            qcnt++;
            gseq.push_back(w);
        end
        @(posedge clk); #1;
        chk("cnt0", 64'(cnt0), 64'(mcnt[0]));
        chk("cnt1", 64'(cnt1), 64'(mcnt[1]));
    endtask

    initial begin
        int w;
        r0_info = '0; r1_info = '0; r0_cancel = 1'b0; r1_cancel = 1'b0;
        do_reset();

        // Contention with a stalled consumer: strict alternation until the queue fills.
        gseq.delete();
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 1'b0, w);
        chk("alt_len", 64'(gseq.size()), 64'd4);
        chk("alt_g0", 64'(gseq[0]), 64'd0);
        chk("alt_g1", 64'(gseq[1]), 64'd1);
        chk("alt_g2", 64'(gseq[2]), 64'd0);
        chk("alt_g3", 64'(gseq[3]), 64'd1);
        chk("alt_cnt0", 64'(cnt0), 64'd2);
        chk("alt_cnt1", 64'(cnt1), 64'd2);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, w);

        // Occupancy cap: fourth request refused although the queue has room.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, w);
        step(1'b1, 1'b0, 1'b0, 1'b0, w);
        chk("cap_q_room", 64'(q_i_ready), 64'd1);
        chk("cap_r0_ready", 64'(r0_ready), 64'd0);
        chk("cap_cnt0", 64'(cnt0), 64'd3);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, w);

        // Fill 0,1,0 and drain in order.
        step(1'b1, 1'b0, 1'b0, 1'b0, w);
        step(1'b0, 1'b1, 1'b0, 1'b0, w);
        step(1'b1, 1'b0, 1'b0, 1'b0, w);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, w);
        chk("drain_cnt0", 64'(cnt0), 64'd0);
        chk("drain_cnt1", 64'(cnt1), 64'd0);

        // Same-cycle accept and pop on requester 1.
        step(1'b0, 1'b1, 1'b0, 1'b0, w);
        step(1'b0, 1'b1, 1'b1, 1'b0, w);
        chk("accpop_cnt1", 64'(cnt1), 64'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, w);

        // Flush: no grant, held entries keep draining.
        step(1'b1, 1'b1, 1'b0, 1'b0, w);
        step(1'b1, 1'b1, 1'b0, 1'b0, w);
        step(1'b1, 1'b1, 1'b1, 1'b1, w);
        chk("flush_nogrant", 64'(w < 0), 64'd1);
        for (int i = 0; i < 4 && qcnt > 0; i++) step(1'b0, 1'b0, 1'b1, 1'b0, w);
        chk("flush_cnt0", 64'(cnt0), 64'd0);
        chk("flush_cnt1", 64'(cnt1), 64'd0);

        // Reset with three entries held; requester 0 wins the first tie afterwards.
        step(1'b1, 1'b1, 1'b0, 1'b0, w);
        step(1'b1, 1'b1, 1'b0, 1'b0, w);
        step(1'b1, 1'b1, 1'b0, 1'b0, w);
        do_reset();
        step(1'b1, 1'b1, 1'b0, 1'b0, w);
        chk("post_rst_winner", 64'(w), 64'd0);
        chk("post_rst_r0", 64'(cnt0), 64'd1);
        step(1'b0, 1'b0, 1'b1, 1'b0, w);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
